// File: rtl/ppe_conv_sequencer.sv
// ppe_conv_sequencer
// Sequences one PPE 1-D convolution: issues paired weight/input RF reads
// for each K-tap window, frames the MAC with clear/enable strobes as the
// responses return, and hands each finished window index downstream via a
// valid/ready handshake.
module ppe_conv_sequencer #(
    parameter int K          = 5,
    parameter int NUM_INPUTS = 25,
    parameter int W_AW       = 3,
    parameter int I_AW       = 5,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_out,
    input  logic             w_loaded,
    input  logic             i_loaded,
    output logic             busy,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [W_AW-1:0]  w_raddr,
    output logic [I_AW-1:0]  i_raddr,
    input  logic             rsp_valid,
    output logic             mac_clr,
    output logic             mac_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_idx,
    output logic             done,
    output logic             err
);

    // Largest legal output count: the last window must end on the last input.
    localparam int MAX_OUT = NUM_INPUTS - K + 1;
    // Outstanding reads range over 0..K.
    localparam int OST_W   = $clog2(K + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_EMIT,
        S_FIN
    } state_t;

    state_t           state_reg;
    logic [W_AW-1:0]  k_iss_reg;
    logic [W_AW-1:0]  k_rsp_reg;
    logic [CNT_W-1:0] j_reg;
    logic [CNT_W-1:0] n_out_reg;
    logic [OST_W-1:0] ost_reg;

    logic in_run;
    logic rd_fire;
    logic rsp_fire;
    logic out_fire;
    logic start_ok;
    logic n_out_bad;
    logic last_iss;
    logic last_rsp;
    logic last_win;

    // Input RF address of tap k of window j; j+k never exceeds NUM_INPUTS-1
    // because n_out is range-checked on start.
    function automatic logic [I_AW-1:0] i_addr(input logic [CNT_W-1:0] jj,
                                               input logic [W_AW-1:0]  kk);
        return I_AW'(jj) + I_AW'(kk);
    endfunction

    // Handshake qualifiers and end-of-sequence decodes.
    always_comb begin
        in_run    = (state_reg == S_ISSUE) || (state_reg == S_DRAIN);
        rd_fire   = rd_valid && rd_ready;
        // A response only counts while a run is active and a read is in flight;
        // stray or post-reset responses are dropped here.
        rsp_fire  = in_run && rsp_valid && (ost_reg != '0);
        out_fire  = out_valid && out_ready;
        start_ok  = start && (state_reg == S_IDLE) && w_loaded && i_loaded;
        n_out_bad = (n_out == '0) || (n_out > CNT_W'(MAX_OUT));
        last_iss  = (k_iss_reg == W_AW'(K - 1));
        last_rsp  = (k_rsp_reg == W_AW'(K - 1));
        last_win  = (j_reg == (n_out_reg - 1'b1));
    end

    // MAC strobes follow the response directly so the product of this
    // response is accumulated in the same cycle it arrives.
    always_comb begin
        mac_en  = rsp_fire;
        mac_clr = rsp_fire && (k_rsp_reg == '0);
    end

    // Outstanding-read counter; an accept and a response in the same cycle cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            ost_reg <= '0;
        end else if (!in_run) begin
            ost_reg <= '0;
        end else begin
            case ({rd_fire, rsp_fire})
                2'b10:   ost_reg <= ost_reg + OST_W'(1);
                2'b01:   ost_reg <= ost_reg - OST_W'(1);
                default: ost_reg <= ost_reg;
            endcase
        end
    end

    // Main sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            k_iss_reg <= '0;
            k_rsp_reg <= '0;
            j_reg     <= '0;
            n_out_reg <= '0;
            busy      <= 1'b0;
            rd_valid  <= 1'b0;
            w_raddr   <= '0;
            i_raddr   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            err  <= 1'b0;
            done <= 1'b0;

            // Response tap counter wraps after the K-th response of a window.
            if (rsp_fire) begin
                k_rsp_reg <= last_rsp ? '0 : k_rsp_reg + 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (start_ok) begin
                        if (n_out_bad) begin
                            err <= 1'b1;
                        end else begin
                            n_out_reg <= n_out;
                            j_reg     <= '0;
                            k_iss_reg <= '0;
                            k_rsp_reg <= '0;
                            state_reg <= S_ISSUE;
                            busy      <= 1'b1;
                            rd_valid  <= 1'b1;
                            w_raddr   <= '0;
                            i_raddr   <= '0;
                        end
                    end
                end

                S_ISSUE: begin
                    if (rd_fire) begin
                        if (last_iss) begin
                            k_iss_reg <= '0;
                            rd_valid  <= 1'b0;
                            state_reg <= S_DRAIN;
                        end else begin
                            k_iss_reg <= k_iss_reg + 1'b1;
                            w_raddr   <= k_iss_reg + 1'b1;
                            i_raddr   <= i_addr(j_reg, k_iss_reg + 1'b1);
                        end
                    end
                end

                S_DRAIN: begin
                    if (rsp_fire && last_rsp) begin
                        state_reg <= S_EMIT;
                        out_valid <= 1'b1;
                        out_idx   <= j_reg;
                    end
                end

                S_EMIT: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                        if (last_win) begin
                            state_reg <= S_FIN;
                            done      <= 1'b1;
                        end else begin
                            // Next window starts issuing right after the handshake.
                            j_reg     <= j_reg + 1'b1;
                            state_reg <= S_ISSUE;
                            rd_valid  <= 1'b1;
                            w_raddr   <= '0;
                            i_raddr   <= i_addr(j_reg + 1'b1, '0);
                        end
                    end
                end

                S_FIN: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end

                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                    rd_valid  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
